// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Recovers a multi-bit rate from a binary spike train. Qualified spikes are
//   counted over a window of WINDOW counting edges. Each window's count is
//   presented on a registered valid/ready output.
//
//   Compile-time option:
//     SPIKE_DEC_EDGE_EN  defined   -> only rising edges of spike_in are counted
//                        undefined -> every high sample of spike_in is counted
//
//   Parameters:
//     WINDOW  counting edges per window (2..65536)
//     CNT_W   width of the result; counts saturate at 2^CNT_W-1
//
//   Ports:
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset
//     en          window counting enable; dropping it discards the partial window
//     spike_in    spike input, sampled on clk
//     rate_ready  downstream accepts rate_out
//     rate_out    count for the last completed window
//     rate_valid  rate_out holds an unconsumed result
//     overrun     sticky: an unconsumed result was overwritten (reset clears)
//
//   All outputs come straight from registers.
module spike_rate_decoder #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             spike_in,
    input  logic             rate_ready,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic             overrun
);

    localparam int              WC_W     = $clog2(WINDOW);
    localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WC_W-1:0]    r_win_cnt;
    logic [CNT_W-1:0]   r_spk_cnt;
    logic               r_spike_q;
    logic [CNT_W-1:0]   r_rate_out;
    logic               r_rate_valid;
    logic               r_overrun;

    state_t             w_state_nxt;
    logic [WC_W-1:0]    w_win_nxt;
    logic [CNT_W-1:0]   w_spk_nxt;
    logic [CNT_W-1:0]   w_rate_nxt;
    logic               w_valid_nxt;
    logic               w_ovr_nxt;

    logic               w_q;
    logic [CNT_W-1:0]   w_spk_sum;
    logic               w_close;
    logic               w_xfer;

`ifdef SPIKE_DEC_EDGE_EN
    // spike_q tracks every edge, so a level held across a window boundary
    // does not produce a second rising edge in the next window.
    assign w_q = spike_in & ~r_spike_q;
`else
    assign w_q = spike_in;
`endif

    // Saturating count including this edge's spike.
    assign w_spk_sum = (r_spk_cnt == CNT_MAX) ? CNT_MAX : (r_spk_cnt + CNT_W'(w_q));
    assign w_close   = (r_state == S_COUNT) && en && (r_win_cnt == WIN_LAST);
    assign w_xfer    = r_rate_valid & rate_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_win_cnt    <= '0;
            r_spk_cnt    <= '0;
            r_spike_q    <= 1'b0;
            r_rate_out   <= '0;
            r_rate_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_win_cnt    <= w_win_nxt;
            r_spk_cnt    <= w_spk_nxt;
            r_spike_q    <= spike_in;
            r_rate_out   <= w_rate_nxt;
            r_rate_valid <= w_valid_nxt;
            r_overrun    <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win_cnt;
        w_spk_nxt   = r_spk_cnt;
        w_rate_nxt  = r_rate_out;
        w_valid_nxt = r_rate_valid;
        w_ovr_nxt   = r_overrun;

        case (r_state)
            S_IDLE: begin
                // The spike on the entry edge is deliberately not counted.
                if (en) begin
                    w_state_nxt = S_COUNT;
                    w_win_nxt   = '0;
                    w_spk_nxt   = '0;
                end
            end
            S_COUNT: begin
                if (!en) begin
                    w_state_nxt = S_IDLE;
                    w_win_nxt   = '0;
                    w_spk_nxt   = '0;
                end else if (w_close) begin
                    // Next window starts on the following edge, no gap.
                    w_win_nxt   = '0;
                    w_spk_nxt   = '0;
                end else begin
                    w_win_nxt   = r_win_cnt + 1'b1;
                    w_spk_nxt   = w_spk_sum;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Output register: a close always wins over a transfer, so valid
        // stays high when both happen on the same edge.
        if (w_close) begin
            w_rate_nxt  = w_spk_sum;
            w_valid_nxt = 1'b1;
            if (r_rate_valid && !rate_ready)
                w_ovr_nxt = 1'b1;
        end else if (w_xfer) begin
            w_valid_nxt = 1'b0;
        end
    end

    assign rate_out   = r_rate_out;
    assign rate_valid = r_rate_valid;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_spike_rate_decoder.sv
module tb_spike_rate_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       spike_in;
    logic       rate_ready;
    logic [3:0] rate_out;
    logic       rate_valid;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];

    spike_rate_decoder #(.WINDOW(16), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .spike_in   (spike_in),
        .rate_ready (rate_ready),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run is a fixed sequence, this only guards against a hang.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Monitor: every transfer (valid & ready seen before an edge) must match
    // the next expected result.
    always @(negedge clk) begin
        if (rst_n && rate_valid && rate_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected got rate_out=%0d expected none", rate_out);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (rate_out !== e) begin
                    errors++;
                    $display("FAIL xfer_rate got %0d expected %0d", rate_out, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs just after a rising edge; they are sampled on the next one.
    task automatic step(input logic e, input logic s);
        en       = e;
        spike_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        step(1'b1, 1'b0);
    endtask

    task automatic run_window(input logic [15:0] pat);
        for (int i = 0; i < 16; i++) step(1'b1, pat[i]);
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        spike_in   = 1'b0;
        rate_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_rate_out", 32'(rate_out), 0);
        chk("reset_valid", 32'(rate_valid), 0);
        chk("reset_overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        step(1'b0, 1'b0);

        // Level count: 5 non-adjacent spikes, valid after the 17th edge.
        rate_ready = 1'b1;
        exp_q.push_back(4'd5);
        start();
        for (int i = 0; i < 15; i++) step(1'b1, (i % 2 == 0) && (i <= 8));
        chk("level_valid_before_close", 32'(rate_valid), 0);
        step(1'b1, 1'b0);
        chk("level_valid_after_17th", 32'(rate_valid), 1);
        chk("level_rate", 32'(rate_out), 5);
        step(1'b0, 1'b0);
        chk("level_pulse_one_cycle", 32'(rate_valid), 0);

        // Saturation: constant high input over two back-to-back windows.
`ifdef SPIKE_DEC_EDGE_EN
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd0);
`else
        exp_q.push_back(4'd15);
        exp_q.push_back(4'd15);
`endif
        start();
        run_window(16'hFFFF);
        chk("sat_valid_w1", 32'(rate_valid), 1);
        step(1'b1, 1'b1);
        chk("sat_valid_drops", 32'(rate_valid), 0);
        for (int i = 1; i < 16; i++) step(1'b1, 1'b1);
        chk("sat_valid_w2", 32'(rate_valid), 1);
        step(1'b0, 1'b0);

        // Overrun: two windows (3 then 7 spikes) with nobody accepting.
        rate_ready = 1'b0;
        exp_q.push_back(4'd7);
        start();
        run_window(16'h0111);
        chk("ovr_first_valid", 32'(rate_valid), 1);
        chk("ovr_first_rate", 32'(rate_out), 3);
        chk("ovr_first_flag", 32'(overrun), 0);
        run_window(16'h1555);
        step(1'b0, 1'b0);
        chk("ovr_rate", 32'(rate_out), 7);
        chk("ovr_valid", 32'(rate_valid), 1);
        chk("ovr_flag", 32'(overrun), 1);
        rate_ready = 1'b1;
        step(1'b0, 1'b0);
        chk("ovr_valid_after_xfer", 32'(rate_valid), 0);
        chk("ovr_flag_sticky", 32'(overrun), 1);
        chk("ovr_rate_held", 32'(rate_out), 7);

        // Abort: 4 spikes in 8 edges, en drops, partial window discarded.
        start();
        for (int i = 0; i < 8; i++) step(1'b1, (i % 2 == 0));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("abort_no_valid", 32'(rate_valid), 0);
        exp_q.push_back(4'd2);
        start();
        run_window(16'h0011);
        chk("abort_rewin_valid", 32'(rate_valid), 1);
        step(1'b0, 1'b0);

        // Edge mode: 10 consecutive high cycles inside one window.
`ifdef SPIKE_DEC_EDGE_EN
        exp_q.push_back(4'd1);
`else
        exp_q.push_back(4'd10);
`endif
        start();
        run_window(16'h0FFC);
        step(1'b0, 1'b0);

        // Reset mid-window with a pending result and overrun set.
        rate_ready = 1'b0;
        start();
        run_window(16'h0005);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
        chk("prerst_valid", 32'(rate_valid), 1);
        chk("prerst_rate", 32'(rate_out), 2);
        chk("prerst_overrun", 32'(overrun), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_rate", 32'(rate_out), 0);
        chk("rst_async_valid", 32'(rate_valid), 0);
        chk("rst_async_overrun", 32'(overrun), 0);
        en = 1'b0;
        spike_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rate_ready = 1'b1;
        exp_q.push_back(4'd3);
        start();
        run_window(16'h0111);
        chk("postrst_valid", 32'(rate_valid), 1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("postrst_overrun", 32'(overrun), 0);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
